cmd_addr_sequencer: RTL and testbench

Upstream driver for the command and address latch units of the ONFI NAND controller. It accepts one request (first command byte, 0–5 address bytes, optional second command byte) and hands each byte to the matching latch unit, one at a time. It waits for each transfer to finish before starting the next. After the last command it inserts the tWB delay, which the command latch does not apply itself, and then reports completion.

---
 rtl/cmd_addr_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_cmd_addr_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_addr_sequencer.sv
// Sequences one ONFI request (cmd0, 0-5 address bytes, optional cmd1) onto the
// command/address latch units, one handshaked byte at a time, then applies tWB.
module cmd_addr_sequencer #(
   parameter int T_WB        = 10,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        start,
   input  logic [7:0]  cmd0,
   input  logic [39:0] addr,
   input  logic [2:0]  addr_cycles,
   input  logic        cmd1_en,
   input  logic [7:0]  cmd1,
   output logic        cmd_activate,
   output logic [15:0] cmd_data,
   input  logic        cmd_busy,
   output logic        addr_activate,
   output logic [15:0] addr_data,
   input  logic        addr_busy,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int CNT_MAX = (T_WB > ACK_TIMEOUT) ? T_WB : ACK_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 2);
   localparam logic [CNT_W-1:0] TWB_LAST = CNT_W'(T_WB);
   localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACK, S_DRAIN, S_TWB} state_t;
   typedef enum logic [1:0] {P_CMD0, P_ADDR, P_CMD1} phase_t;

   state_t           state_q, state_d;
   phase_t           phase_q, phase_d;
   logic [2:0]       idx_q, idx_d;
   logic [2:0]       naddr_q, naddr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       cmd0_q, cmd0_d;
   logic [7:0]       cmd1_q, cmd1_d;
   logic             cmd1_en_q, cmd1_en_d;
   logic [39:0]      addr_q, addr_d;

   logic             cmd_activate_q, cmd_activate_d;
   logic             addr_activate_q, addr_activate_d;
   logic [15:0]      cmd_data_q, cmd_data_d;
   logic [15:0]      addr_data_q, addr_data_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;

   logic             sel_busy_s;
   logic             xfer_s;
   logic [7:0]       byte_s;

   function automatic logic [7:0] addr_byte(input logic [39:0] a, input logic [2:0] i);
      case (i)
         3'd0:    addr_byte = a[7:0];
         3'd1:    addr_byte = a[15:8];
         3'd2:    addr_byte = a[23:16];
         3'd3:    addr_byte = a[31:24];
         3'd4:    addr_byte = a[39:32];
         default: addr_byte = 8'h00;
      endcase
   endfunction

   assign sel_busy_s = (phase_q == P_ADDR) ? addr_busy : cmd_busy;

   // Next-state, request capture and next values of every registered output
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      idx_d     = idx_q;
      naddr_d   = naddr_q;
      cnt_d     = cnt_q;
      cmd0_d    = cmd0_q;
      cmd1_d    = cmd1_q;
      cmd1_en_d = cmd1_en_q;
      addr_d    = addr_q;
      error_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cmd0_d    = cmd0;
               cmd1_d    = cmd1;
               cmd1_en_d = cmd1_en;
               addr_d    = addr;
               naddr_d   = (addr_cycles > 3'd5) ? 3'd5 : addr_cycles;
               phase_d   = P_CMD0;
               idx_d     = 3'd0;
               cnt_d     = '0;
               state_d   = S_ISSUE;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_ACK;
         end
         S_ACK: begin
            if (sel_busy_s) begin
               state_d = S_DRAIN;
            end else if (cnt_q == ACK_LAST) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         S_DRAIN: begin
            if (sel_busy_s) begin
               state_d = S_DRAIN;
            end else if ((phase_q == P_CMD0) && (naddr_q != 3'd0)) begin
               phase_d = P_ADDR;
               idx_d   = 3'd0;
               state_d = S_ISSUE;
            end else if ((phase_q == P_ADDR) && ((idx_q + 3'd1) < naddr_q)) begin
               idx_d   = idx_q + 3'd1;
               state_d = S_ISSUE;
            end else if ((phase_q != P_CMD1) && cmd1_en_q) begin
               phase_d = P_CMD1;
               state_d = S_ISSUE;
            end else begin
               cnt_d   = '0;
               state_d = S_TWB;
            end
         end
         S_TWB: begin
            if (cnt_q == TWB_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The data bus stays valid through the latch unit's whole active window
      xfer_s = (state_d == S_ISSUE) || (state_d == S_ACK) || (state_d == S_DRAIN);
      case (phase_d)
         P_CMD0:  byte_s = cmd0_d;
         P_ADDR:  byte_s = addr_byte(addr_d, idx_d);
         P_CMD1:  byte_s = cmd1_d;
         default: byte_s = 8'h00;
      endcase

      cmd_activate_d  = (state_d == S_ISSUE) && (phase_d != P_ADDR);
      addr_activate_d = (state_d == S_ISSUE) && (phase_d == P_ADDR);
      cmd_data_d      = (xfer_s && (phase_d != P_ADDR)) ? {8'h00, byte_s} : 16'h0000;
      addr_data_d     = (xfer_s && (phase_d == P_ADDR)) ? {8'h00, byte_s} : 16'h0000;
      busy_d          = (state_d != S_IDLE);
      done_d          = (state_d == S_TWB) && (cnt_d == TWB_LAST);
   end

   // State, captured request and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q         <= S_IDLE;
         phase_q         <= P_CMD0;
         idx_q           <= 3'd0;
         naddr_q         <= 3'd0;
         cnt_q           <= '0;
         cmd0_q          <= 8'h00;
         cmd1_q          <= 8'h00;
         cmd1_en_q       <= 1'b0;
         addr_q          <= 40'h0;
         cmd_activate_q  <= 1'b0;
         addr_activate_q <= 1'b0;
         cmd_data_q      <= 16'h0000;
         addr_data_q     <= 16'h0000;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         phase_q         <= phase_d;
         idx_q           <= idx_d;
         naddr_q         <= naddr_d;
         cnt_q           <= cnt_d;
         cmd0_q          <= cmd0_d;
         cmd1_q          <= cmd1_d;
         cmd1_en_q       <= cmd1_en_d;
         addr_q          <= addr_d;
         cmd_activate_q  <= cmd_activate_d;
         addr_activate_q <= addr_activate_d;
         cmd_data_q      <= cmd_data_d;
         addr_data_q     <= addr_data_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         error_q         <= error_d;
      end
   end

   assign cmd_activate  = cmd_activate_q;
   assign addr_activate = addr_activate_q;
   assign cmd_data      = cmd_data_q;
   assign addr_data     = addr_data_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;

endmodule

// File: tb/tb_cmd_addr_sequencer.sv
// Scoreboard bench for cmd_addr_sequencer: directed requests push expected latch
// events; a negedge monitor pops and compares every activate/done/error it sees.
module tb_cmd_addr_sequencer;

   localparam int T_WB        = 10;
   localparam int ACK_TIMEOUT = 15;
   localparam int L_CMD       = 3;
   localparam int L_ADDR      = 2;

   localparam logic [1:0] K_CMD  = 2'd0;
   localparam logic [1:0] K_ADDR = 2'd1;
   localparam logic [1:0] K_DONE = 2'd2;
   localparam logic [1:0] K_ERR  = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  cmd0 = 8'h00;
   logic [39:0] addr = 40'h0;
   logic [2:0]  addr_cycles = 3'd0;
   logic        cmd1_en = 1'b0;
   logic [7:0]  cmd1 = 8'h00;
   logic        cmd_activate, addr_activate, busy, done, error;
   logic [15:0] cmd_data, addr_data;
   logic        cmd_busy, addr_busy;

   exp_t sbq[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   c_pulses = 0, a_pulses = 0, n_done = 0, n_err = 0;
   int   iss_cyc = 0, done_cyc = 0, err_cyc = 0, cfall_cyc = 0, start_cyc = 0;
   logic prev_cbusy = 1'b0;
   logic [7:0] c_byte = 8'h00, a_byte = 8'h00;

   // Latch unit models: busy rises one cycle after the activate is registered
   logic c_pre = 1'b0, a_pre = 1'b0;
   int   c_left = 0, a_left = 0;
   bit   cmd_stub = 1'b0;

   cmd_addr_sequencer #(.T_WB(T_WB), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk(clk), .nreset(nreset), .start(start), .cmd0(cmd0), .addr(addr),
      .addr_cycles(addr_cycles), .cmd1_en(cmd1_en), .cmd1(cmd1),
      .cmd_activate(cmd_activate), .cmd_data(cmd_data), .cmd_busy(cmd_busy),
      .addr_activate(addr_activate), .addr_data(addr_data), .addr_busy(addr_busy),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      c_pre  <= cmd_activate && !cmd_stub;
      a_pre  <= addr_activate;
      c_left <= c_pre ? L_CMD : ((c_left > 0) ? c_left - 1 : 0);
      a_left <= a_pre ? L_ADDR : ((a_left > 0) ? a_left - 1 : 0);
   end

   assign cmd_busy  = (c_left != 0);
   assign addr_busy = (a_left != 0);

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic push(input logic [1:0] k, input logic [7:0] d);
      exp_t e;
      e.kind = k;
      e.data = d;
      sbq.push_back(e);
   endtask

   // Monitor: pop and compare on every DUT event, plus bus-level invariants
   always @(negedge clk) begin : mon
      logic [1:0]  kind;
      logic [15:0] data;
      exp_t        e;
      if (cmd_activate || addr_activate || done || error) begin
         if (cmd_activate) begin
            kind = K_CMD; data = cmd_data; c_pulses++; iss_cyc = cyc;
         end else if (addr_activate) begin
            kind = K_ADDR; data = addr_data; a_pulses++;
         end else if (done) begin
            kind = K_DONE; data = 16'h0000; n_done++; done_cyc = cyc;
         end else begin
            kind = K_ERR; data = 16'h0000; n_err++; err_cyc = cyc;
         end
         if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: kind %0d data %h with nothing expected", kind, data);
         end else begin
            e = sbq.pop_front();
            check("event_kind", 64'(kind), 64'(e.kind));
            if (kind == K_CMD || kind == K_ADDR)
               check("event_data", 64'(data), 64'({8'h00, e.data}));
            if (kind == K_CMD) c_byte = e.data;
            if (kind == K_ADDR) a_byte = e.data;
         end
      end
      if (cmd_activate || addr_activate)
         check("activate_exclusive", 64'(cmd_activate & addr_activate), 64'd0);
      if (!busy)
         check("idle_buses_zero", 64'({cmd_data, addr_data}), 64'd0);
      if (busy && !cmd_activate && (c_pre || c_left != 0))
         check("cmd_data_hold", 64'(cmd_data), 64'({8'h00, c_byte}));
      if (busy && !addr_activate && (a_pre || a_left != 0))
         check("addr_data_hold", 64'(addr_data), 64'({8'h00, a_byte}));
      if (prev_cbusy && !cmd_busy) cfall_cyc = cyc;
      prev_cbusy = cmd_busy;
   end

   task automatic issue_req(input logic [7:0] c0, input logic [39:0] a, input logic [2:0] ac,
                            input logic en, input logic [7:0] c1);
      @(negedge clk); #1;
      cmd0 = c0; addr = a; addr_cycles = ac; cmd1_en = en; cmd1 = c1;
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_quiet(input string name, input int budget);
      int k;
      k = 0;
      while ((sbq.size() != 0 || busy) && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      check(name, 64'(sbq.size() != 0 || busy), 64'd0);
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, 64'({cmd_activate, addr_activate, busy, done, error, cmd_data, addr_data}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bc, ba, bd, k;

      repeat (3) @(negedge clk);
      #1;
      check_outputs_zero("reset_outputs");
      check("reset_busy", 64'(busy), 64'd0);
      nreset = 1'b1;
      repeat (2) @(negedge clk);

      // Single command byte, no address, no cmd1
      bc = c_pulses; ba = a_pulses; bd = n_done;
      push(K_CMD, 8'hFF); push(K_DONE, 8'h00);
      issue_req(8'hFF, 40'h0, 3'd0, 1'b0, 8'h00);
      wait_quiet("t1_complete", 200);
      check("t1_start_to_issue", 64'(iss_cyc - start_cyc), 64'd1);
      check("t1_cmd_pulses", 64'(c_pulses - bc), 64'd1);
      check("t1_addr_pulses", 64'(a_pulses - ba), 64'd0);
      check("t1_done_count", 64'(n_done - bd), 64'd1);
      check("t1_done_after_busy_fall", 64'(done_cyc - cfall_cyc), 64'(T_WB + 1));

      // Full request: cmd0, five address bytes, cmd1
      bc = c_pulses; ba = a_pulses; bd = n_done;
      push(K_CMD, 8'h00);
      push(K_ADDR, 8'h00); push(K_ADDR, 8'h01); push(K_ADDR, 8'h02);
      push(K_ADDR, 8'h03); push(K_ADDR, 8'h04);
      push(K_CMD, 8'h30); push(K_DONE, 8'h00);
      issue_req(8'h00, 40'h0403020100, 3'd5, 1'b1, 8'h30);
      wait_quiet("t2_complete", 400);
      check("t2_cmd_pulses", 64'(c_pulses - bc), 64'd2);
      check("t2_addr_pulses", 64'(a_pulses - ba), 64'd5);
      check("t2_done_count", 64'(n_done - bd), 64'd1);

      // start held high for the whole sequence while the inputs change
      bd = n_done;
      push(K_CMD, 8'h12); push(K_ADDR, 8'h34); push(K_CMD, 8'h56); push(K_DONE, 8'h00);
      @(negedge clk); #1;
      cmd0 = 8'h12; addr = 40'h0000000034; addr_cycles = 3'd1; cmd1_en = 1'b1; cmd1 = 8'h56;
      start = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (done) break;
         cmd0 = 8'hEE; addr = 40'hEEEEEEEEEE; addr_cycles = 3'd5; cmd1 = 8'hEE;
      end
      start = 1'b0;
      wait_quiet("t3_complete", 50);
      repeat (5) @(negedge clk);
      #1;
      check("t3_done_count", 64'(n_done - bd), 64'd1);
      check("t3_idle_after", 64'(busy), 64'd0);

      // Command latch never acknowledges
      bd = n_done;
      cmd_stub = 1'b1;
      push(K_CMD, 8'h90); push(K_ERR, 8'h00);
      issue_req(8'h90, 40'h0, 3'd0, 1'b0, 8'h00);
      wait_quiet("t4_error_seen", 100);
      check("t4_error_latency", 64'(err_cyc - iss_cyc), 64'(ACK_TIMEOUT + 1));
      check("t4_no_done", 64'(n_done - bd), 64'd0);
      cmd_stub = 1'b0;
      push(K_CMD, 8'h70); push(K_ADDR, 8'hAA); push(K_ADDR, 8'hBB); push(K_DONE, 8'h00);
      issue_req(8'h70, 40'h000000BBAA, 3'd2, 1'b0, 8'h00);
      wait_quiet("t4_next_request", 300);

      // Reset while address byte 2 is being issued
      ba = a_pulses;
      push(K_CMD, 8'h80);
      push(K_ADDR, 8'h11); push(K_ADDR, 8'h22); push(K_ADDR, 8'h33);
      issue_req(8'h80, 40'h5544332211, 3'd5, 1'b1, 8'h10);
      k = 0;
      while ((a_pulses - ba) < 3 && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      check("t5_reached_addr_byte2", 64'(a_pulses - ba), 64'd3);
      nreset = 1'b0;
      sbq.delete();
      @(negedge clk); #1;
      check_outputs_zero("t5_outputs_after_reset");
      nreset = 1'b1;
      k = 0;
      while ((a_pre || a_left != 0 || c_pre || c_left != 0) && k < 50) begin
         @(negedge clk); #1;
         k++;
      end
      bd = n_done;
      push(K_CMD, 8'h60);
      push(K_ADDR, 8'hAA); push(K_ADDR, 8'hBB); push(K_ADDR, 8'hCC);
      push(K_DONE, 8'h00);
      issue_req(8'h60, 40'h0000CCBBAA, 3'd3, 1'b0, 8'h00);
      wait_quiet("t5_request_after_reset", 300);
      check("t5_done_count", 64'(n_done - bd), 64'd1);

      // addr_cycles above five is clamped to five
      ba = a_pulses;
      push(K_CMD, 8'h05);
      push(K_ADDR, 8'hF0); push(K_ADDR, 8'hF1); push(K_ADDR, 8'hF2);
      push(K_ADDR, 8'hF3); push(K_ADDR, 8'hF4);
      push(K_DONE, 8'h00);
      issue_req(8'h05, 40'hF4F3F2F1F0, 3'd7, 1'b0, 8'h00);
      wait_quiet("t6_complete", 400);
      check("t6_addr_pulses", 64'(a_pulses - ba), 64'd5);

      repeat (5) @(negedge clk);
      #1;
      check("final_queue_empty", 64'(sbq.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
